if_fetch: RTL and testbench
===========================

Name: if_fetch

Overview:
- Instruction-fetch initiator sitting in front of the combinational instruction memory.
- Owns the PC register and drives the fetch address.
- Captures the returned instruction and access-fault information into a registered valid/ready bundle for decode.
- Handles trap and branch redirects, misaligned targets, and a fault-hold state, so each memory fault is reported exactly once.

Parameters:
- RESET_PC, 64'h0000_0000_0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h00000013, instruction placed in the bundle when no valid memory data applies.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- imem_addr  output  64  fetch address to instruction memory; equals the PC register (combinational from it)
- imem_instr  input  32  instruction word returned for imem_addr, same cycle
- imem_exc_en  input  1  memory reports access fault for imem_addr
- imem_exc_code  input  4  memory fault cause
- imem_exc_val  input  64  memory fault value (bad PC)
- trap_valid  input  1  trap taken; redirect to trap_pc
- trap_pc  input  64  trap vector target
- redir_valid  input  1  branch/jump redirect
- redir_pc  input  64  redirect target
- if_valid  output  1  bundle valid to decode
- if_ready  input  1  decode accepts bundle this cycle
- if_pc  output  64  PC of bundle
- if_instr  output  32  instruction of bundle
- if_exc_en  output  1  bundle carries an exception
- if_exc_code  output  4  exception cause
- if_exc_val  output  64  exception value
- perf_fetched  output  64  bundles loaded (see optional feature)
- perf_stalls  output  64  stall cycles (see optional feature)

Behaviour:
- Reset (rst=1 at clock edge, any state, overrides everything):
  - pc=RESET_PC, state=RUN.
  - if_valid=0, if_pc=0, if_instr=NOP_INSTR.
  - if_exc_en=0, if_exc_code=0, if_exc_val=0.
  - Perf counters = 0.
- States: RUN (fetching), HOLD (fault reported, fetch suspended).
- Load condition: load = (state==RUN) && (!if_valid || if_ready) && !trap_valid && !redir_valid.
- Load, pc[1:0]==2'b00:
  - if_valid<=1, if_pc<=pc, if_instr<=imem_instr.
  - Exception fields copied from imem_exc_*.
  - If imem_exc_en=0: pc<=pc+4, modulo 2^64 (wrap from 64'hFFFF_FFFF_FFFF_FFFC to 0).
  - If imem_exc_en=1: if_instr<=NOP_INSTR, pc unchanged, state<=HOLD.
- Load, pc[1:0]!=0 (misaligned):
  - imem inputs ignored.
  - if_instr<=NOP_INSTR, if_exc_en<=1, if_exc_code<=4'd0 (instruction address misaligned), if_exc_val<=pc.
  - pc unchanged, state<=HOLD.
- No load, if_valid=1, if_ready=1: if_valid<=0. Other bundle fields hold.
- No load, if_valid=1, if_ready=0: all bundle fields hold (stable while unaccepted).
- HOLD:
  - No loads; pc frozen.
  - Bundle drains normally via if_ready.
  - Exited only by trap, redirect or reset.
- Redirect priority: rst > trap_valid > redir_valid > load.
  - Trap: pc<=trap_pc, if_valid<=0 (flush, even if unaccepted), state<=RUN, exception fields cleared.
  - Redirect: same as trap but with redir_pc.
  - Trap and redirect in the same cycle: trap wins; redir_pc discarded.
  - Target is fetched on the following cycle; the misaligned check applies to it.
- Throughput and latency:
  - One bundle per cycle while if_ready=1.
  - Redirect-to-first-bundle latency: 2 cycles (PC load, then bundle load).
- Each memory fault yields exactly one bundle with if_exc_en=1. The bundle is never duplicated, because the PC is frozen in HOLD.

Optional Feature:
- Macro IF_PERF_CNT_EN.
- Defined:
  - perf_fetched increments on each load (wraps at 2^64).
  - perf_stalls increments each cycle with if_valid=1 && if_ready=0.
  - Both reset to 0.
- Undefined: perf_fetched and perf_stalls tied to 64'h0; no counter flops.

Test Plan:
- Reset release with RESET_PC=0, imem returns 32'h00500093 at addr 0, if_ready=1 -> imem_addr=0; next cycle if_valid=1, if_pc=0, if_instr=32'h00500093; then imem_addr=4.
- Backpressure: if_ready=0 for 3 cycles after a bundle at pc 8 -> if_pc=8 and if_instr stable, imem_addr stays 12; perf_stalls=3 with IF_PERF_CNT_EN.
- Access fault: imem_exc_en=1, code 4'd1, val 64'h2_0000 at pc 64'h2_0000 -> one bundle with if_exc_en=1, code 1, val 64'h2_0000, if_instr=32'h00000013; if_valid then 0 indefinitely and pc frozen until trap.
- Trap and redirect same cycle: trap_pc=64'h100, redir_pc=64'h200 while an unaccepted bundle is pending -> if_valid=0 next cycle, imem_addr=64'h100, next bundle if_pc=64'h100.
- Misaligned redirect: redir_pc=64'h102 -> bundle if_exc_en=1, code 0, val 64'h102, state HOLD; a subsequent trap to 64'h0 resumes fetch.
- Reset mid-HOLD with if_valid=1 -> next cycle if_valid=0, imem_addr=RESET_PC, fetch resumes.

Source files
------------

// File: rtl/if_fetch.sv
// Instruction-fetch initiator: owns the PC, fetches from combinational imem and
// registers a valid/ready bundle for decode. Optional counters under IF_PERF_CNT_EN.
module if_fetch #(
    parameter logic [63:0] RESET_PC  = 64'h0000_0000_0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        imem_exc_en,
    input  logic [3:0]  imem_exc_code,
    input  logic [63:0] imem_exc_val,
    input  logic        trap_valid,
    input  logic [63:0] trap_pc,
    input  logic        redir_valid,
    input  logic [63:0] redir_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [63:0] if_pc,
    output logic [31:0] if_instr,
    output logic        if_exc_en,
    output logic [3:0]  if_exc_code,
    output logic [63:0] if_exc_val,
    output logic [63:0] perf_fetched,
    output logic [63:0] perf_stalls
);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [63:0] pc;
    logic [0:0]  state;
    logic        load;
    logic        misaligned;

    assign imem_addr  = pc;
    assign misaligned = (pc[1:0] != 2'b00);
    assign load       = (state == ST_RUN) && (!if_valid || if_ready) && !trap_valid && !redir_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            state       <= ST_RUN;
            if_valid    <= 1'b0;
            if_pc       <= 64'h0;
            if_instr    <= NOP_INSTR;
            if_exc_en   <= 1'b0;
            if_exc_code <= 4'h0;
            if_exc_val  <= 64'h0;
        end else if (trap_valid || redir_valid) begin
            // Flush any pending bundle, even one decode has not yet taken.
            pc          <= trap_valid ? trap_pc : redir_pc;
            state       <= ST_RUN;
            if_valid    <= 1'b0;
            if_exc_en   <= 1'b0;
            if_exc_code <= 4'h0;
            if_exc_val  <= 64'h0;
        end else if (load) begin
            if_valid <= 1'b1;
            if_pc    <= pc;
            if (misaligned) begin
                if_instr    <= NOP_INSTR;
                if_exc_en   <= 1'b1;
                if_exc_code <= 4'd0;
                if_exc_val  <= pc;
                state       <= ST_HOLD;
            end else begin
                if_exc_en   <= imem_exc_en;
                if_exc_code <= imem_exc_code;
                if_exc_val  <= imem_exc_val;
                if (imem_exc_en) begin
                    // Freezing the PC in HOLD keeps the fault from being reported twice.
                    if_instr <= NOP_INSTR;
                    state    <= ST_HOLD;
                end else begin
                    if_instr <= imem_instr;
                    pc       <= pc + 64'd4;
                end
            end
        end else if (if_valid && if_ready) begin
            if_valid <= 1'b0;
        end
    end

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched <= 64'h0;
            perf_stalls  <= 64'h0;
        end else begin
            if (load) perf_fetched <= perf_fetched + 64'd1;
            if (if_valid && !if_ready) perf_stalls <= perf_stalls + 64'd1;
        end
    end
`else
    assign perf_fetched = 64'h0;
    assign perf_stalls  = 64'h0;
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Randomized scoreboard bench for if_fetch against a behavioural fetch-stream model.
module tb_if_fetch;

    localparam logic [31:0] NOP = 32'h00000013;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        exc_en;
        logic [3:0]  code;
        logic [63:0] val;
    } bundle_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr;
    logic        imem_exc_en;
    logic [3:0]  imem_exc_code;
    logic [63:0] imem_exc_val;
    logic        trap_valid = 1'b0;
    logic [63:0] trap_pc = 64'h0;
    logic        redir_valid = 1'b0;
    logic [63:0] redir_pc = 64'h0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [63:0] if_pc;
    logic [31:0] if_instr;
    logic        if_exc_en;
    logic [3:0]  if_exc_code;
    logic [63:0] if_exc_val;
    logic [63:0] perf_fetched;
    logic [63:0] perf_stalls;

    int checks = 0;
    int errors = 0;

    bundle_t     sb_q[$];
    logic [63:0] m_pc;
    logic        m_vld;
    logic        m_hold;
    bundle_t     m_b;
    logic [63:0] m_fetched;
    logic [63:0] m_stalls;

    if_fetch dut (
        .clk(clk), .rst(rst),
        .imem_addr(imem_addr), .imem_instr(imem_instr),
        .imem_exc_en(imem_exc_en), .imem_exc_code(imem_exc_code), .imem_exc_val(imem_exc_val),
        .trap_valid(trap_valid), .trap_pc(trap_pc),
        .redir_valid(redir_valid), .redir_pc(redir_pc),
        .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr),
        .if_exc_en(if_exc_en), .if_exc_code(if_exc_code), .if_exc_val(if_exc_val),
        .perf_fetched(perf_fetched), .perf_stalls(perf_stalls)
    );

    always #5 clk = ~clk;

    // Memory contents: a fixed function of the address.
    function automatic logic mem_fault(input logic [63:0] a);
        logic [7:0] w;
        w = a[9:2];
        return (a == 64'h2_0000) || (a < 64'h400 && (w % 13) == 5);
    endfunction

    function automatic logic [31:0] mem_instr(input logic [63:0] a);
        logic [31:0] lo;
        lo = a[31:0];
        return (a == 64'h0) ? 32'h00500093 : ((lo * 32'h9E3779B1) ^ 32'h01234567);
    endfunction

    function automatic logic [3:0] mem_code(input logic [63:0] a);
        if (mem_fault(a)) return (a == 64'h2_0000) ? 4'd1 : 4'd5;
        return a[9:6];
    endfunction

    function automatic logic [63:0] mem_val(input logic [63:0] a);
        return mem_fault(a) ? a : ~a;
    endfunction

    assign imem_instr    = mem_instr(imem_addr);
    assign imem_exc_en   = mem_fault(imem_addr);
    assign imem_exc_code = mem_code(imem_addr);
    assign imem_exc_val  = mem_val(imem_addr);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted bundle must be the next one the model issued.
    always @(negedge clk) begin
        if (rst === 1'b0 && if_valid === 1'b1 && if_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_bundle: got pc %h expected none", if_pc);
            end else begin
                bundle_t e;
                e = sb_q.pop_front();
                chk("sb_pc", if_pc, e.pc);
                chk("sb_instr", {32'h0, if_instr}, {32'h0, e.instr});
                chk("sb_exc_en", {63'h0, if_exc_en}, {63'h0, e.exc_en});
                chk("sb_exc_code", {60'h0, if_exc_code}, {60'h0, e.code});
                chk("sb_exc_val", if_exc_val, e.val);
            end
        end
    end

    // One clock cycle: drive inputs, advance the model on the edge, check visible state.
    task automatic cycle(input logic r, input logic tv, input logic [63:0] tp,
                         input logic rv, input logic [63:0] rp, input logic rdy);
        bundle_t nb;
        rst = r; trap_valid = tv; trap_pc = tp; redir_valid = rv; redir_pc = rp; if_ready = rdy;
        @(posedge clk);
        if (r) begin
            m_pc = 64'h0; m_vld = 1'b0; m_hold = 1'b0;
            m_b = '{pc: 64'h0, instr: NOP, exc_en: 1'b0, code: 4'h0, val: 64'h0};
            m_fetched = 64'h0; m_stalls = 64'h0;
            sb_q.delete();
        end else begin
            if (m_vld && !rdy) m_stalls++;
            if (tv || rv) begin
                if (m_vld && !rdy && sb_q.size() > 0) nb = sb_q.pop_back();
                m_pc = tv ? tp : rp;
                m_vld = 1'b0; m_hold = 1'b0;
                m_b.exc_en = 1'b0; m_b.code = 4'h0; m_b.val = 64'h0;
            end else if (!m_hold && (!m_vld || rdy)) begin
                if (m_pc[1:0] != 2'b00) begin
                    nb = '{pc: m_pc, instr: NOP, exc_en: 1'b1, code: 4'd0, val: m_pc};
                    m_hold = 1'b1;
                end else if (mem_fault(m_pc)) begin
                    nb = '{pc: m_pc, instr: NOP, exc_en: 1'b1, code: mem_code(m_pc), val: mem_val(m_pc)};
                    m_hold = 1'b1;
                end else begin
                    nb = '{pc: m_pc, instr: mem_instr(m_pc), exc_en: 1'b0, code: mem_code(m_pc), val: mem_val(m_pc)};
                    m_pc = m_pc + 64'd4;
                end
                m_b = nb; m_vld = 1'b1; m_fetched++;
                sb_q.push_back(nb);
            end else if (m_vld && rdy) begin
                m_vld = 1'b0;
            end
        end
        #1;
        chk("imem_addr", imem_addr, m_pc);
        chk("if_valid", {63'h0, if_valid}, {63'h0, m_vld});
        chk("if_pc", if_pc, m_b.pc);
        chk("if_instr", {32'h0, if_instr}, {32'h0, m_b.instr});
        chk("if_exc_en", {63'h0, if_exc_en}, {63'h0, m_b.exc_en});
        chk("if_exc_code", {60'h0, if_exc_code}, {60'h0, m_b.code});
        chk("if_exc_val", if_exc_val, m_b.val);
`ifdef IF_PERF_CNT_EN
        chk("perf_fetched", perf_fetched, m_fetched);
        chk("perf_stalls", perf_stalls, m_stalls);
`else
        chk("perf_fetched", perf_fetched, 64'h0);
        chk("perf_stalls", perf_stalls, 64'h0);
`endif
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 64'h0, 1'b0, 64'h0, rdy);
    endtask

    function automatic logic [63:0] rand_target();
        logic [63:0] t;
        case ($urandom % 7)
            0: t = 64'(($urandom % 256) * 4);
            1: t = {32'h0, $urandom} | 64'h2;
            2: t = 64'hFFFF_FFFF_FFFF_FFF0;
            3: t = 64'h2_0000;
            4: t = 64'h100;
            5: t = {$urandom, $urandom} & ~64'h3;
            default: t = 64'h1 + 64'(($urandom % 64) * 4);
        endcase
        return t;
    endfunction

    initial begin
        // Reset and first fetches, then backpressure at pc 8.
        cycle(1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 1'b1);
        cycle(1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 1'b1);
        idle(3, 1'b1);
        idle(3, 1'b0);
        idle(2, 1'b1);
        // Access fault, then HOLD until trap.
        cycle(1'b0, 1'b0, 64'h0, 1'b1, 64'h2_0000, 1'b1);
        idle(6, 1'b1);
        // Trap and redirect together while a bundle sits unaccepted.
        cycle(1'b0, 1'b1, 64'h40, 1'b0, 64'h0, 1'b1);
        idle(2, 1'b0);
        cycle(1'b0, 1'b1, 64'h100, 1'b1, 64'h200, 1'b0);
        idle(3, 1'b1);
        // Misaligned redirect, then trap to 0 resumes.
        cycle(1'b0, 1'b0, 64'h0, 1'b1, 64'h102, 1'b1);
        idle(4, 1'b1);
        cycle(1'b0, 1'b1, 64'h0, 1'b0, 64'h0, 1'b1);
        idle(3, 1'b1);
        // PC wrap at the top of the address space.
        cycle(1'b0, 1'b0, 64'h0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 1'b1);
        idle(4, 1'b1);
        // Reset in the middle of HOLD with a bundle still pending.
        cycle(1'b0, 1'b0, 64'h0, 1'b1, 64'h2_0000, 1'b1);
        idle(1, 1'b0);
        cycle(1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
        idle(3, 1'b1);
        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            logic tv, rv, rr;
            tv = ($urandom % 20) == 0;
            rv = ($urandom % 9) == 0;
            rr = ($urandom % 400) == 0;
            cycle(rr, tv, rand_target(), rv, rand_target(), ($urandom % 4) != 0);
        end
        idle(4, 1'b1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
